// File: rtl/plat_draw_pkg.sv
// Shared constants and slot-table entry type for the platform sprite renderer.
package plat_draw_pkg;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned SPR_W     = 32;
    localparam int unsigned SPR_H     = 8;
    localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
    } plat_entry_t;

endpackage

// File: rtl/plat_hit_sel.sv
// Combinational priority hit-test of one pixel against the active platform table.
// The border output exists only when PLAT_DEBUG_OUTLINE_EN is defined.
module plat_hit_sel import plat_draw_pkg::*; #(
    parameter int unsigned  NUM_PLAT = 8,
    parameter int unsigned  SPR_W    = plat_draw_pkg::SPR_W,
    parameter int unsigned  SPR_H    = plat_draw_pkg::SPR_H,
    localparam int unsigned ROW_W    = $clog2(SPR_H),
    localparam int unsigned COL_W    = $clog2(SPR_W)
) (
    input  plat_entry_t [NUM_PLAT-1:0] plat_tbl,
    input  logic [9:0]                 draw_x,
    input  logic [9:0]                 draw_y,
    output logic                       any_hit,
    output logic [ROW_W-1:0]           row,
    output logic [COL_W-1:0]           col
`ifdef PLAT_DEBUG_OUTLINE_EN
    ,
    output logic                       border
`endif
);

    logic [10:0] px;
    logic [10:0] py;
    logic        on_screen;

    always_comb begin
        px        = {1'b0, draw_x};
        py        = {1'b0, draw_y};
        on_screen = (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
        any_hit   = 1'b0;
        row       = '0;
        col       = '0;
        // Walk from the top slot down so the lowest matching index is assigned last.
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (on_screen && plat_tbl[i].en &&
                px >= {1'b0, plat_tbl[i].x} && px < {1'b0, plat_tbl[i].x} + 11'(SPR_W) &&
                py >= {1'b0, plat_tbl[i].y} && py < {1'b0, plat_tbl[i].y} + 11'(SPR_H)) begin
                any_hit = 1'b1;
                col     = COL_W'(px - {1'b0, plat_tbl[i].x});
                row     = ROW_W'(py - {1'b0, plat_tbl[i].y});
            end
        end
    end

`ifdef PLAT_DEBUG_OUTLINE_EN
    assign border = any_hit && (row == '0 || row == ROW_W'(SPR_H - 1) ||
                                col == '0 || col == COL_W'(SPR_W - 1));
`endif

endmodule

// File: rtl/platform_draw.sv
// Platform sprite renderer: double-buffered slot table, hit-test, ROM addressing and
// 3-cycle colour realignment. Define PLAT_DEBUG_OUTLINE_EN to draw red sprite outlines.
module platform_draw import plat_draw_pkg::*; #(
    parameter int unsigned  NUM_PLAT  = 8,
    parameter int unsigned  SPR_W     = plat_draw_pkg::SPR_W,
    parameter int unsigned  SPR_H     = plat_draw_pkg::SPR_H,
    parameter logic [23:0]  KEY_COLOR = plat_draw_pkg::KEY_COLOR,
    localparam int unsigned IDX_W     = $clog2(NUM_PLAT),
    localparam int unsigned ROW_W     = $clog2(SPR_H),
    localparam int unsigned COL_W     = $clog2(SPR_W)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_start,
    input  logic             plat_we,
    input  logic [IDX_W-1:0] plat_idx,
    input  logic             plat_en,
    input  logic [9:0]       plat_x,
    input  logic [9:0]       plat_y,
    input  logic             pix_req,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    output logic [8:0]       rom_addr,
    input  logic [23:0]      rom_data,
    output logic             plat_hit,
    output logic [23:0]      plat_rgb
);

    plat_entry_t [NUM_PLAT-1:0] pend_q;
    plat_entry_t [NUM_PLAT-1:0] act_q;
    plat_entry_t                wr_entry;

    assign wr_entry = '{en: plat_en, x: plat_x, y: plat_y};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            if (plat_we) begin
                pend_q[plat_idx] <= wr_entry;
            end
            if (frame_start) begin
                // A write landing on the swap cycle is forwarded so it shows this frame.
                for (int i = 0; i < NUM_PLAT; i++) begin
                    act_q[i] <= (plat_we && plat_idx == IDX_W'(i)) ? wr_entry : pend_q[i];
                end
            end
        end
    end

    logic             any_hit;
    logic [ROW_W-1:0] sel_row;
    logic [COL_W-1:0] sel_col;
    logic             hit0;
    logic [8:0]       addr0;

    plat_hit_sel #(
        .NUM_PLAT (NUM_PLAT),
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H)
    ) u_hit_sel (
        .plat_tbl (act_q),
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .any_hit  (any_hit),
        .row      (sel_row),
        .col      (sel_col)
`ifdef PLAT_DEBUG_OUTLINE_EN
        ,
        .border   (border0)
`endif
    );

    assign hit0  = pix_req && any_hit;
    assign addr0 = 9'(sel_row) * 9'(SPR_W) + 9'(sel_col);

    logic        hit1_q;
    logic        hit2_q;
    logic        hit_d;
    logic [23:0] rgb_d;

`ifdef PLAT_DEBUG_OUTLINE_EN
    logic border0;
    logic bord1_q;
    logic bord2_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bord1_q <= 1'b0;
            bord2_q <= 1'b0;
        end else begin
            bord1_q <= hit0 && border0;
            bord2_q <= bord1_q;
        end
    end
`endif

    always_comb begin
        hit_d = hit2_q && (rom_data != KEY_COLOR);
        rgb_d = hit_d ? rom_data : '0;
`ifdef PLAT_DEBUG_OUTLINE_EN
        if (hit2_q && bord2_q) begin
            hit_d = 1'b1;
            rgb_d = 24'hFF0000;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
            plat_hit <= 1'b0;
            plat_rgb <= '0;
        end else begin
            hit1_q <= hit0;
            if (hit0) begin
                rom_addr <= addr0;
            end
            hit2_q   <= hit1_q;
            plat_hit <= hit_d;
            plat_rgb <= rgb_d;
        end
    end

endmodule

// File: tb/tb_platform_draw.sv
// Self-checking bench for platform_draw with a behavioural slot-table and ROM model.
module tb_platform_draw;

    localparam int NP = 8;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        plat_we = 1'b0;
    logic [2:0]  plat_idx = '0;
    logic        plat_en = 1'b0;
    logic [9:0]  plat_x = '0;
    logic [9:0]  plat_y = '0;
    logic        pix_req = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [8:0]  rom_addr;
    logic [23:0] rom_data = '0;
    logic        plat_hit;
    logic [23:0] plat_rgb;

    platform_draw dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .plat_we     (plat_we),
        .plat_idx    (plat_idx),
        .plat_en     (plat_en),
        .plat_x      (plat_x),
        .plat_y      (plat_y),
        .pix_req     (pix_req),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .plat_hit    (plat_hit),
        .plat_rgb    (plat_rgb)
    );

    always #5 Clk = ~Clk;

    logic [23:0] rom [256];
    always @(posedge Clk) rom_data <= rom[rom_addr[7:0]];

    typedef struct {
        bit          hit;
        logic [23:0] rgb;
    } res_t;

    bit   m_pen_en [NP];
    int   m_pen_x  [NP];
    int   m_pen_y  [NP];
    bit   m_aen    [NP];
    int   m_ax     [NP];
    int   m_ay     [NP];
    res_t q[$];

    logic        exp_hit;
    logic [23:0] exp_rgb;
    logic [8:0]  exp_addr;
    int tests_run = 0;
    int tests_failed = 0;

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_pen_en[i] = 0; m_pen_x[i] = 0; m_pen_y[i] = 0;
            m_aen[i] = 0; m_ax[i] = 0; m_ay[i] = 0;
        end
        q.delete();
        // Two flushed pipeline stages behave like two earlier non-hit pixels.
        q.push_back('{hit: 1'b0, rgb: 24'h0});
        q.push_back('{hit: 1'b0, rgb: 24'h0});
        exp_addr = '0;
        exp_hit  = 1'b0;
        exp_rgb  = '0;
    endtask

    function automatic bit find_slot(input bit req, input int x, input int y,
                                     output int addr, output bit border);
        addr = 0;
        border = 0;
        if (!req || x >= 640 || y >= 480) return 0;
        for (int i = 0; i < NP; i++) begin
            if (m_aen[i] && x >= m_ax[i] && x < m_ax[i] + 32 && y >= m_ay[i] && y < m_ay[i] + 8) begin
                addr   = (y - m_ay[i]) * 32 + (x - m_ax[i]);
                border = (y == m_ay[i]) || (y == m_ay[i] + 7) || (x == m_ax[i]) || (x == m_ax[i] + 31);
                return 1;
            end
        end
        return 0;
    endfunction

    // Advance one clock, updating the reference model and the expected outputs.
    task automatic tick();
        bit   h;
        bit   b;
        int   a;
        res_t r;
        h = find_slot(pix_req, int'(DrawX), int'(DrawY), a, b);
        r.hit = 1'b0;
        r.rgb = '0;
        if (h) begin
            exp_addr = 9'(a);
            if (rom[a] != KEY) begin
                r.hit = 1'b1;
                r.rgb = rom[a];
            end
`ifdef PLAT_DEBUG_OUTLINE_EN
            if (b) begin
                r.hit = 1'b1;
                r.rgb = 24'hFF0000;
            end
`endif
        end
        q.push_back(r);
        @(posedge Clk);
        #1;
        if (plat_we) begin
            m_pen_en[plat_idx] = plat_en;
            m_pen_x[plat_idx]  = int'(plat_x);
            m_pen_y[plat_idx]  = int'(plat_y);
        end
        if (frame_start) begin
            m_aen = m_pen_en;
            m_ax  = m_pen_x;
            m_ay  = m_pen_y;
        end
        r = q.pop_front();
        exp_hit = r.hit;
        exp_rgb = r.rgb;
    endtask

    task automatic write_slot(input int idx, input bit en, input int x, input int y, input bit fs);
        pix_req = 1'b0;
        plat_we = 1'b1;
        plat_idx = 3'(idx);
        plat_en = en;
        plat_x = 10'(x);
        plat_y = 10'(y);
        frame_start = fs;
        tick();
        plat_we = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        pix_req = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #12;
        tests_run++;
        if (rom_addr !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_rom_addr: got %0d, expected 0", rom_addr);
        end
        tests_run++;
        if (plat_hit !== 1'b0 || plat_rgb !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got hit=%b rgb=%h, expected hit=0 rgb=000000", plat_hit, plat_rgb);
        end
        #4 Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        write_slot(0, 1, 100, 200, 0);
        pulse_frame();
        for (int k = 0; k < 42; k++) begin
            pix_req = (k < 40);
            DrawX = 10'(96 + k);
            DrawY = 10'd200;
            tick();
            tests_run++;
            if (plat_hit !== exp_hit || plat_rgb !== exp_rgb || rom_addr !== exp_addr) begin
                tests_failed++;
                $display("FAIL scan k=%0d: got hit=%b rgb=%h addr=%0d, expected hit=%b rgb=%h addr=%0d",
                         k, plat_hit, plat_rgb, rom_addr, exp_hit, exp_rgb, exp_addr);
            end
        end
    endtask

    task automatic test_pending();
        write_slot(2, 1, 300, 50, 0);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) begin
                pix_req = (k == 0);
                DrawX = 10'd300;
                DrawY = 10'd50;
                tick();
                tests_run++;
                if (plat_hit !== exp_hit || plat_rgb !== exp_rgb || rom_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL pending pass=%0d k=%0d: got hit=%b rgb=%h addr=%0d, expected hit=%b rgb=%h addr=%0d",
                             pass, k, plat_hit, plat_rgb, rom_addr, exp_hit, exp_rgb, exp_addr);
                end
                if (pass == 1 && k == 0) begin
                    tests_run++;
                    if (rom_addr !== 9'd0) begin
                        tests_failed++;
                        $display("FAIL pending_addr: got %0d, expected 0", rom_addr);
                    end
                end
            end
            tests_run++;
            if (plat_hit !== (pass == 1)) begin
                tests_failed++;
                $display("FAIL pending_hit pass=%0d: got %b, expected %b", pass, plat_hit, pass == 1);
            end
            if (pass == 0) pulse_frame();
        end
    endtask

    task automatic test_overlap();
        write_slot(3, 1, 400, 100, 1);
        write_slot(1, 1, 400, 100, 0);
        pulse_frame();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                write_slot(1, 1, 404, 101, 0);
                pulse_frame();
            end
            for (int k = 0; k < 32; k++) begin
                pix_req = (k < 30);
                DrawX = 10'($urandom_range(440, 396));
                DrawY = 10'($urandom_range(110, 98));
                tick();
                tests_run++;
                if (plat_hit !== exp_hit || plat_rgb !== exp_rgb || rom_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL overlap ph=%0d k=%0d: got hit=%b rgb=%h addr=%0d, expected hit=%b rgb=%h addr=%0d",
                             phase, k, plat_hit, plat_rgb, rom_addr, exp_hit, exp_rgb, exp_addr);
                end
            end
        end
    endtask

    task automatic test_edge();
        write_slot(5, 1, 620, 300, 1);
        for (int k = 0; k < 26; k++) begin
            pix_req = (k < 24);
            DrawX = (k < 12) ? 10'(628 + k) : 10'(k - 12);
            DrawY = 10'd302;
            tick();
            tests_run++;
            if (plat_hit !== exp_hit || plat_rgb !== exp_rgb || rom_addr !== exp_addr) begin
                tests_failed++;
                $display("FAIL edge k=%0d: got hit=%b rgb=%h addr=%0d, expected hit=%b rgb=%h addr=%0d",
                         k, plat_hit, plat_rgb, rom_addr, exp_hit, exp_rgb, exp_addr);
            end
            if (k == 2) begin
                tests_run++;
                if (rom_addr !== 9'd74) begin
                    tests_failed++;
                    $display("FAIL edge_col10: got %0d, expected 74", rom_addr);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        write_slot(4, 1, 10, 10, 1);
        for (int k = 0; k < 3; k++) begin
            pix_req = (k == 0);
            DrawX = 10'd10;
            DrawY = 10'd10;
            tick();
            tests_run++;
            if (plat_hit !== exp_hit || plat_rgb !== exp_rgb || rom_addr !== exp_addr) begin
                tests_failed++;
                $display("FAIL same_cycle k=%0d: got hit=%b rgb=%h addr=%0d, expected hit=%b rgb=%h addr=%0d",
                         k, plat_hit, plat_rgb, rom_addr, exp_hit, exp_rgb, exp_addr);
            end
        end
        tests_run++;
        if (plat_hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_cycle_hit: got %b, expected 1", plat_hit);
        end
    endtask

    task automatic test_random();
        int s;
        int lo;
        int hi;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(99, 0) < 5) begin
                plat_we = 1'b1;
                plat_idx = 3'($urandom_range(NP - 1, 0));
                plat_en = ($urandom_range(3, 0) != 0);
                plat_x = 10'($urandom_range(639, 0));
                plat_y = 10'($urandom_range(479, 0));
                frame_start = ($urandom_range(9, 0) < 3);
            end else if ($urandom_range(99, 0) < 3) begin
                frame_start = 1'b1;
            end
            s = $urandom_range(NP - 1, 0);
            lo = (m_ax[s] < 4) ? 0 : m_ax[s] - 4;
            hi = (m_ax[s] + 35 > 639) ? 639 : m_ax[s] + 35;
            DrawX = 10'($urandom_range(hi, lo));
            lo = (m_ay[s] < 2) ? 0 : m_ay[s] - 2;
            hi = (m_ay[s] + 9 > 479) ? 479 : m_ay[s] + 9;
            DrawY = 10'($urandom_range(hi, lo));
            pix_req = ($urandom_range(9, 0) != 0);
            tick();
            plat_we = 1'b0;
            frame_start = 1'b0;
            tests_run++;
            if (plat_hit !== exp_hit || plat_rgb !== exp_rgb || rom_addr !== exp_addr) begin
                tests_failed++;
                $display("FAIL random k=%0d: got hit=%b rgb=%h addr=%0d, expected hit=%b rgb=%h addr=%0d",
                         k, plat_hit, plat_rgb, rom_addr, exp_hit, exp_rgb, exp_addr);
            end
        end
    endtask

    task automatic test_reset_mid();
        write_slot(0, 1, 100, 200, 1);
        for (int k = 0; k < 4; k++) begin
            pix_req = 1'b1;
            DrawX = 10'(100 + k);
            DrawY = 10'd200;
            tick();
        end
        tests_run++;
        if (plat_hit !== 1'b1 || plat_hit !== exp_hit) begin
            tests_failed++;
            $display("FAIL reset_mid_prehit: got %b, expected 1", plat_hit);
        end
        #2 Reset_n = 1'b0;
        #1;
        tests_run++;
        if (plat_hit !== 1'b0 || plat_rgb !== 24'h0 || rom_addr !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_flush: got hit=%b rgb=%h addr=%0d, expected 0 0 0",
                     plat_hit, plat_rgb, rom_addr);
        end
        #2 Reset_n = 1'b1;
        model_reset();
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 1) pulse_frame();
            if (phase == 2) write_slot(0, 1, 100, 200, 1);
            for (int k = 0; k < 6; k++) begin
                pix_req = (k < 4);
                DrawX = 10'(100 + k);
                DrawY = 10'd200;
                tick();
                tests_run++;
                if (plat_hit !== exp_hit || plat_rgb !== exp_rgb || rom_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL reset_mid ph=%0d k=%0d: got hit=%b rgb=%h addr=%0d, expected hit=%b rgb=%h addr=%0d",
                             phase, k, plat_hit, plat_rgb, rom_addr, exp_hit, exp_rgb, exp_addr);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = ($urandom_range(3, 0) == 0) ? KEY : 24'($urandom);
        end
        for (int i = 0; i < 4; i++) rom[i] = 24'h102030 + 24'(i);
        rom[5] = KEY;
        test_reset();
        test_scan();
        test_pending();
        test_overlap();
        test_edge();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
